// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces a push-button into press/release pulses, an LED toggle and a saturating press count.
// Optional KEY_LONG_PRESS_EN adds a hold counter that pulses long_press once per sufficiently long press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4000000,
    parameter int LONG_CYCLES     = 200000000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter int CNT_W           = 8
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             key_in,
    output logic             key_state,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             led_toggle,
    output logic [CNT_W-1:0] press_cnt,
    output logic             long_press
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          sample;
    logic          prev;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_nxt;
    logic          stable;

    assign sample  = sync[1] ^ KEY_ACTIVE_LOW;
    assign cnt_nxt = (sample != prev) ? '0 : (cnt == DMAX) ? cnt : cnt + 1'b1;
    // accept on the edge where the counter arrives at DEBOUNCE_CYCLES
    assign stable  = cnt_nxt == DMAX;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {2{KEY_ACTIVE_LOW}};
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], key_in};
            prev <= sample;
            cnt  <= cnt_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            led_toggle    <= 1'b0;
            press_cnt     <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: if (sample) state <= PRESS_WAIT;
                PRESS_WAIT:
                    if (!sample) state <= IDLE;
                    else if (stable) begin
                        state       <= PRESSED;
                        key_state   <= 1'b1;
                        press_pulse <= 1'b1;
                        led_toggle  <= ~led_toggle;
                        press_cnt   <= press_cnt + CNT_W'(press_cnt != '1);
                    end
                PRESSED: if (!sample) state <= RELEASE_WAIT;
                RELEASE_WAIT:
                    if (sample) state <= PRESSED;
                    else if (stable) begin
                        state         <= IDLE;
                        key_state     <= 1'b0;
                        release_pulse <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LMAX = LW'(LONG_CYCLES);

    logic [LW-1:0] hold;

    // hold pauses in RELEASE_WAIT and saturates at LMAX so the pulse fires once per press
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= '0;
            long_press <= 1'b0;
        end else begin
            hold       <= (state == PRESSED) ? ((hold == LMAX) ? hold : hold + 1'b1) :
                          (state == RELEASE_WAIT) ? hold : '0;
            long_press <= (state == PRESSED) && (hold == LMAX - 1'b1);
        end
    end
`else
    // constant 0; the comparison only keeps LONG_CYCLES referenced
    assign long_press = LONG_CYCLES < 0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench; stimulus queues expected pulse events, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_key_debounce;
    localparam logic [2:0] PR = 3'b001, RL = 3'b010, LG = 3'b100;

    typedef struct packed {
        logic [2:0] kind;
        int         cyc;
        logic       st;
        logic       tg;
        logic [1:0] cnt;
    } ev_t;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       key_in;
    logic       key_state;
    logic       press_pulse;
    logic       release_pulse;
    logic       led_toggle;
    logic [1:0] press_cnt;
    logic       long_press;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  q[$];
    logic exp_tg;
    logic [1:0] exp_cnt;
    int   last_press;
    int   sat_exp[5] = '{1, 2, 3, 3, 3};

    key_debounce #(
        .DEBOUNCE_CYCLES(16),
        .LONG_CYCLES    (64),
        .KEY_ACTIVE_LOW (1'b1),
        .CNT_W          (2)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .key_state    (key_state),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .led_toggle   (led_toggle),
        .press_cnt    (press_cnt),
        .long_press   (long_press)
    );

    always #2.5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outs(input string name, input int ks, input int tg, input int cnt);
        check({name, " key_state"}, key_state, ks);
        check({name, " press_pulse"}, press_pulse, 0);
        check({name, " release_pulse"}, release_pulse, 0);
        check({name, " led_toggle"}, led_toggle, tg);
        check({name, " press_cnt"}, press_cnt, cnt);
        check({name, " long_press"}, long_press, 0);
    endtask

    task automatic expect_ev(input logic [2:0] k, input int c, input logic s, input logic t, input logic [1:0] n);
        q.push_back('{kind: k, cyc: c, st: s, tg: t, cnt: n});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic set_key(input logic v);
        @(negedge sys_clk);
        key_in = v;
    endtask

    task automatic press(input bit expect_long);
        set_key(1'b0);
        exp_tg     = ~exp_tg;
        exp_cnt    = (exp_cnt == 2'd3) ? exp_cnt : exp_cnt + 2'd1;
        last_press = cyc + 19;
        expect_ev(PR, last_press, 1'b1, exp_tg, exp_cnt);
`ifdef KEY_LONG_PRESS_EN
        if (expect_long) expect_ev(LG, last_press + 64, 1'b1, exp_tg, exp_cnt);
`endif
    endtask

    task automatic release_key();
        set_key(1'b1);
        expect_ev(RL, cyc + 19, 1'b0, exp_tg, exp_cnt);
    endtask

    initial begin
        ev_t e;
        forever begin
            @(negedge sys_clk);
            if (press_pulse || release_pulse || long_press) begin
                if (q.size() == 0) begin
                    check("unexpected pulse", {long_press, release_pulse, press_pulse}, 0);
                end else begin
                    e = q.pop_front();
                    check("event kind", {long_press, release_pulse, press_pulse}, e.kind);
                    check("event cycle", cyc, e.cyc);
                    check("event key_state", key_state, e.st);
                    check("event led_toggle", led_toggle, e.tg);
                    check("event press_cnt", press_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        key_in  = 1'b1;
        exp_tg  = 1'b0;
        exp_cnt = 2'd0;
        #1000;
        check_outs("reset", 0, 0, 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        idle(2000);
        check_outs("idle", 0, 0, 0);

        press(1'b1);
        idle(100);
        check("clean press key_state", key_state, 1);
        check("clean press led_toggle", led_toggle, 1);
        check("clean press press_cnt", press_cnt, 1);
        release_key();
        idle(40);
        check("release key_state", key_state, 0);
        check("release press_cnt", press_cnt, 1);

        for (int i = 0; i < 12; i++) begin
            set_key(i[0]);
            idle(4);
        end
        press(1'b0);
        idle(40);
        set_key(1'b1);
        idle(9);
        set_key(1'b0);
        idle(30);
        check("high glitch key_state", key_state, 1);
        release_key();
        idle(40);
        set_key(1'b0);
        idle(9);
        set_key(1'b1);
        idle(40);
        check("low glitch key_state", key_state, 0);
        check("bounce press_cnt", press_cnt, 2);

        @(negedge sys_clk);
        rst_n = 1'b0;
        idle(5);
        rst_n   = 1'b1;
        exp_tg  = 1'b0;
        exp_cnt = 2'd0;
        idle(40);
        for (int i = 0; i < 5; i++) begin
            press(1'b0);
            idle(30);
            check("saturation press_cnt", press_cnt, sat_exp[i]);
            release_key();
            idle(30);
        end
        check("saturation led_toggle", led_toggle, 1);

        press(1'b0);
        idle(40);
        @(negedge sys_clk);
        rst_n = 1'b0;
        idle(4);
        check_outs("mid-press reset", 0, 0, 0);
        rst_n      = 1'b1;
        exp_tg     = 1'b1;
        exp_cnt    = 2'd1;
        last_press = cyc + 19;
        expect_ev(PR, last_press, 1'b1, exp_tg, exp_cnt);
`ifdef KEY_LONG_PRESS_EN
        expect_ev(LG, last_press + 64, 1'b1, exp_tg, exp_cnt);
`endif
        idle(150);
        check("held after reset key_state", key_state, 1);
        release_key();
        idle(40);

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge sys_clk);
        check("pending events", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
